// File: rtl/warp_scheduler_pkg.sv
// warp_scheduler_pkg: FSM state encoding and default sizes shared with fetch and decode
// Contents: state_t (IDLE, RUN, DONE), DEFAULT_NUM_WARPS, DEFAULT_PC_WIDTH
package warp_scheduler_pkg;
    localparam int DEFAULT_NUM_WARPS = 4;
    localparam int DEFAULT_PC_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// warp_scheduler_rr_arbiter: combinational round-robin pick of the next eligible warp
// Ports: eligible (per-warp request mask), last_issued (previous grant),
//        grant_valid (some warp eligible), grant_id (first eligible after last_issued)
module warp_scheduler_rr_arbiter
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = DEFAULT_NUM_WARPS,
    parameter int WID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] eligible,
    input  logic [WID_WIDTH-1:0] last_issued,
    output logic                 grant_valid,
    output logic [WID_WIDTH-1:0] grant_id
);
    logic [WID_WIDTH-1:0] idx;
    // Scan from the farthest candidate to the nearest so the nearest eligible one wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id = '0;
        idx = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            idx = WID_WIDTH'((int'(last_issued) + i) % NUM_WARPS);
            if (eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id = idx;
            end
        end
    end
endmodule

// File: rtl/warp_scheduler.sv
// warp_scheduler: per-warp PC file, kernel FSM and round-robin issue of warp PCs
// Ports: clk, reset (async, active-high); start/base_pc/warp_enable launch a kernel;
//        warp_stall masks warps; branch_* redirect and halt_* retire a warp;
//        global_advance steps global_pc; pc/issue_valid/issue_warp carry the issued
//        warp PC; busy/done report RUN/DONE.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS = DEFAULT_NUM_WARPS,
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH,
    parameter int WID_WIDTH = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  base_pc,
    input  logic [NUM_WARPS-1:0] warp_enable,
    input  logic [NUM_WARPS-1:0] warp_stall,
    input  logic                 branch_valid,
    input  logic [WID_WIDTH-1:0] branch_warp,
    input  logic [PC_WIDTH-1:0]  branch_target,
    input  logic                 halt_valid,
    input  logic [WID_WIDTH-1:0] halt_warp,
    input  logic                 global_advance,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  global_pc,
    output logic                 issue_valid,
    output logic [WID_WIDTH-1:0] issue_warp,
    output logic                 busy,
    output logic                 done
);
    localparam logic [WID_WIDTH-1:0] LAST_INIT = WID_WIDTH'(NUM_WARPS - 1);
    state_t               state;
    logic [PC_WIDTH-1:0]  warp_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0] active;
    logic [NUM_WARPS-1:0] next_active;
    logic [WID_WIDTH-1:0] last_issued;
    logic                 grant_valid;
    logic [WID_WIDTH-1:0] grant_id;
    logic                 issue;
    logic                 branch_ok;
    warp_scheduler_rr_arbiter #(
        .NUM_WARPS(NUM_WARPS),
        .WID_WIDTH(WID_WIDTH)
    ) u_arb (
        .eligible(active & ~warp_stall),
        .last_issued(last_issued),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );
    always_comb begin
        next_active = active;
        if (halt_valid) next_active[halt_warp] = 1'b0;
    end
    // The edge that retires the last warp enters DONE, where nothing may issue.
    assign issue = grant_valid && next_active != '0;
    // A halt on the same warp suppresses its branch.
    assign branch_ok = branch_valid && active[branch_warp] && !(halt_valid && halt_warp == branch_warp);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            global_pc <= '0;
            issue_valid <= 1'b0;
            issue_warp <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            active <= '0;
            last_issued <= LAST_INIT;
            for (int w = 0; w < NUM_WARPS; w++) warp_pc[w] <= '0;
        end else begin
            case (state)
                RUN: begin
                    issue_valid <= issue;
                    if (issue) begin
                        issue_warp <= grant_id;
                        pc <= warp_pc[grant_id];
                        warp_pc[grant_id] <= warp_pc[grant_id] + 1'b1;
                        last_issued <= grant_id;
                    end
                    if (branch_ok) warp_pc[branch_warp] <= branch_target;
                    active <= next_active;
                    if (global_advance) global_pc <= global_pc + 1'b1;
                    if (next_active == '0) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                IDLE, DONE: begin
                    issue_valid <= 1'b0;
                    if (start && warp_enable != '0) begin
                        state <= RUN;
                        busy <= 1'b1;
                        done <= 1'b0;
                        active <= warp_enable;
                        global_pc <= base_pc;
                        last_issued <= LAST_INIT;
                        for (int w = 0; w < NUM_WARPS; w++)
                            if (warp_enable[w]) warp_pc[w] <= base_pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: Warp_Scheduler

Interface
REQ-001 Parameters: NUM_WARPS, default 4, number of warp contexts; PC_WIDTH, default 8, width of every PC; WID_WIDTH, default 2, equal to clog2(NUM_WARPS).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that launches a kernel; sampled only in IDLE or DONE.
REQ-005 base_pc  input  PC_WIDTH  launch PC, loaded into every enabled warp and into global_pc on start.
REQ-006 warp_enable  input  NUM_WARPS  warps participating in the kernel; sampled on start.
REQ-007 warp_stall  input  NUM_WARPS  per-warp hold from decode/execute; a stalled warp is not eligible.
REQ-008 branch_valid / branch_warp / branch_target  input  1 / WID_WIDTH / PC_WIDTH  redirect a warp's PC.
REQ-009 halt_valid / halt_warp  input  1 / WID_WIDTH  retire a warp.
REQ-010 global_advance  input  1  step the global instruction stream.
REQ-011 pc  output  PC_WIDTH  registered PC of the issued warp, feeding instruction fetch.
REQ-012 global_pc  output  PC_WIDTH  registered global-stream PC, feeding instruction fetch.
REQ-013 issue_valid / issue_warp  output  1 / WID_WIDTH  pc is valid this cycle and belongs to issue_warp.
REQ-014 busy / done  output  1 / 1  kernel running / all warps halted.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE to RUN on start with warp_enable != 0.
- RUN to DONE when the active mask becomes 0.
- DONE to RUN on start.
- start with warp_enable == 0 leaves the state unchanged.
REQ-016 On start, the block SHALL:
- set each enabled warp's PC to base_pc and its active bit to 1;
- clear the active bit of each non-enabled warp;
- set global_pc to base_pc.
REQ-017 In RUN, a warp is eligible when it is active and its warp_stall bit is 0.
REQ-018 Selection SHALL be round-robin: starting at (last_issued+1) mod NUM_WARPS, take the first eligible warp. last_issued resets to NUM_WARPS-1, so warp 0 gets first priority.
REQ-019 Issue latency SHALL be 1 cycle: on the edge after a cycle with an eligible warp W, issue_valid=1, issue_warp=W and pc=PC[W] as it was before the edge; PC[W] increments by 1 on that same edge.
REQ-020 With no eligible warp: issue_valid=0 on the next cycle; pc and issue_warp hold their previous values.
REQ-021 PC arithmetic SHALL be modulo 2^PC_WIDTH, so PC 0xFF increments to 0x00.
REQ-022 branch_valid SHALL load branch_target into PC[branch_warp] on the next edge. It takes priority over the issue increment when it names the warp being issued that cycle. It is ignored for inactive warps.
REQ-023 halt_valid SHALL clear active[halt_warp] on the next edge. A warp halted in the same cycle it is selected is still issued that cycle. When halt and branch name the same warp, halt wins.
REQ-024 global_pc SHALL increment by 1, mod 2^PC_WIDTH, on each edge with global_advance=1 in RUN; otherwise it holds.
REQ-025 Output levels by state:
- busy=1 only in RUN;
- done=1 only in DONE;
- issue_valid=0 in IDLE and DONE.
REQ-026 start arriving in RUN SHALL be ignored.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for clk, force all of the following, including mid-kernel:
- state=IDLE;
- pc=0, global_pc=0;
- issue_valid=0, issue_warp=0;
- busy=0, done=0;
- all active bits 0;
- all warp PCs 0;
- last_issued=NUM_WARPS-1.
REQ-028 After reset is released, no issue SHALL occur until a start is accepted.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state encoding (IDLE, RUN, DONE);
- default NUM_WARPS and PC_WIDTH, shared with instruction fetch and decode.
REQ-030 The round-robin picker SHALL be one combinational sub-module, RR_Arbiter, with inputs eligible mask and last_issued and outputs grant_valid and grant_id. The per-warp PC file and the FSM stay in Warp_Scheduler.

Verification
REQ-031 Start with base_pc=0x10, warp_enable=4'b1111 and no stalls. Required: issue_warp sequence 0,1,2,3,0 with pcs 0x10,0x10,0x10,0x10,0x11.
REQ-032 Stall warp 1 continuously, all four warps enabled. Required: issue order 0,2,3,0,2; warp 1 never issued.
REQ-033 Branch warp 2 to 0x40 in the same cycle warp 2 is selected. Required: that issue shows the old PC, and warp 2's next issue shows 0x40, not old+1.
REQ-034 Enable warps 0 and 1; warp 0 reaches PC 0xFF. Required: its next-but-one issue shows 0x00. Halt both warps. Required: done=1, busy=0, issue_valid=0 one cycle after the last halt.
REQ-035 Assert reset mid-RUN, between clock edges. Required: outputs zero before the next edge; a subsequent start with base_pc=0x20 restarts cleanly from warp 0 at 0x20.
REQ-036 Pulse global_advance 3 times after start with base_pc=0x05. Required: global_pc=0x08. start during RUN leaves global_pc and the warp PCs unchanged.
